// File: rtl/mem1_stage.sv
// MEM1 pipeline stage: holds one instruction from EXE, issues its data SRAM
// request (address phase only) and hands the instruction on to MEM2.
module mem1_stage #(
    parameter int IN_WD  = 175,
    parameter int OUT_WD = 79
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_to_m1s_valid,
    input  logic [IN_WD-1:0]  es_to_m1s_bus,
    output logic              m1s_allowin,
    input  logic              m2s_allowin,
    output logic              m1s_to_m2s_valid,
    output logic [OUT_WD-1:0] m1s_to_m2s_bus,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              flush,
    output logic              m1s_ex,
    output logic              m1s_inst_eret,
    output logic [4:0]        M1_dest,
    output logic [31:0]       M1_result,
    output logic              m1s_load_op
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, CANCEL} state_t;

    state_t             state, state_nxt;
    logic               m1s_valid;
    logic [IN_WD-1:0]   bus_r;

    logic [31:0] wdata, alu_result;
    logic [3:0]  wen;
    logic [4:0]  exctype, dest;
    logic        mem_we, load_op, ex, eret, gr_we;
    logic        need_mem, ready_go, issued, leaving;
    logic        unused_bits;

    assign wdata      = bus_r[174:143];
    assign wen        = bus_r[142:139];
    assign mem_we     = bus_r[138];
    assign load_op    = bus_r[133];
    assign ex         = bus_r[127];
    assign exctype    = bus_r[126:122];
    assign eret       = bus_r[120];
    assign gr_we      = bus_r[69];
    assign dest       = bus_r[68:64];
    assign alu_result = bus_r[63:32];
    assign unused_bits = &{1'b0, bus_r[137:134], bus_r[132:128], bus_r[121], bus_r[119:70]};

    // Excepting instructions never touch memory.
    assign need_mem = m1s_valid & (load_op | mem_we) & ~ex;

    // Request FSM. A request, once raised, is held until accepted even if the
    // instruction is flushed underneath it (CANCEL drains it).
    always_comb begin
        state_nxt = state;
        data_req  = 1'b0;
        case (state)
            IDLE: begin
                data_req = need_mem & ~flush;
                if (need_mem & ~flush) begin
                    if (data_addr_ok) state_nxt = m2s_allowin ? IDLE : DONE;
                    else              state_nxt = REQ;
                end
            end
            REQ: begin
                data_req = 1'b1;
                if (data_addr_ok)  state_nxt = (flush | m2s_allowin) ? IDLE : DONE;
                else if (flush)    state_nxt = CANCEL;
            end
            DONE: begin
                if (flush | leaving) state_nxt = IDLE;
            end
            CANCEL: begin
                data_req = 1'b1;
                if (data_addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready_go = ~need_mem | (state == DONE) |
                      (((state == IDLE) | (state == REQ)) & data_req & data_addr_ok);
    assign issued   = need_mem & ready_go;

    assign m1s_to_m2s_valid = m1s_valid & ready_go & ~flush;
    assign leaving          = m1s_to_m2s_valid & m2s_allowin;
    assign m1s_allowin      = (~m1s_valid | (ready_go & m2s_allowin)) & (state != CANCEL);
    assign m1s_to_m2s_bus   = {issued, ex, exctype, eret, load_op, bus_r[69:0]};

    // Request fields come straight from the held payload, so they stay stable
    // for as long as the request is outstanding.
    assign data_wr    = mem_we;
    assign data_addr  = alu_result;
    assign data_wstrb = load_op ? 4'b0000 : wen;
    assign data_wdata = wdata;

    assign m1s_ex        = m1s_valid & ex;
    assign m1s_inst_eret = m1s_valid & eret;
    assign m1s_load_op   = m1s_valid & load_op;
    assign M1_dest       = m1s_valid ? dest : 5'd0;
    assign M1_result     = alu_result;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stage valid: flush always empties the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           m1s_valid <= 1'b0;
        else if (flush)       m1s_valid <= 1'b0;
        else if (m1s_allowin) m1s_valid <= es_to_m1s_valid;
    end

    // Payload register, loaded only when a new instruction actually enters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                      bus_r <= '0;
        else if (m1s_allowin & es_to_m1s_valid & ~flush) bus_r <= es_to_m1s_bus;
    end

endmodule

// File: tb/tb_mem1_stage.sv
// Directed bench for mem1_stage with an output scoreboard.
module tb_mem1_stage;

    logic         clk, reset;
    logic         es_to_m1s_valid;
    logic [174:0] es_to_m1s_bus;
    logic         m1s_allowin, m2s_allowin, m1s_to_m2s_valid;
    logic [78:0]  m1s_to_m2s_bus;
    logic         data_req, data_wr, data_addr_ok, flush;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_addr, data_wdata, M1_result;
    logic         m1s_ex, m1s_inst_eret, m1s_load_op;
    logic [4:0]   M1_dest;

    int total = 0;
    int bad   = 0;
    logic [78:0] sb[$];

    mem1_stage #(.IN_WD(175), .OUT_WD(79)) dut (
        .clk(clk), .reset(reset),
        .es_to_m1s_valid(es_to_m1s_valid), .es_to_m1s_bus(es_to_m1s_bus),
        .m1s_allowin(m1s_allowin), .m2s_allowin(m2s_allowin),
        .m1s_to_m2s_valid(m1s_to_m2s_valid), .m1s_to_m2s_bus(m1s_to_m2s_bus),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .flush(flush), .m1s_ex(m1s_ex), .m1s_inst_eret(m1s_inst_eret),
        .M1_dest(M1_dest), .M1_result(M1_result), .m1s_load_op(m1s_load_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [174:0] mk(input logic [31:0] wd, input logic [3:0] wen,
                                        input logic mem_we, input logic ld, input logic ex,
                                        input logic [4:0] exc, input logic eret,
                                        input logic gr_we, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc);
        logic [174:0] b;
        b = '0;
        b[174:143] = wd;  b[142:139] = wen; b[138] = mem_we; b[133] = ld;
        b[127] = ex;      b[126:122] = exc; b[120] = eret;
        b[69] = gr_we;    b[68:64] = dest;  b[63:32] = alu;  b[31:0] = pc;
        return b;
    endfunction

    function automatic logic [78:0] xo(input logic iss, input logic [174:0] b);
        return {iss, b[127], b[126:122], b[120], b[133], b[69:0]};
    endfunction

    task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare any instruction handed to M2 this cycle, then advance one clock.
    task automatic tick();
        if (m1s_to_m2s_valid && m2s_allowin) begin
            if (sb.size() == 0) chk("sb_unexpected_out", m1s_to_m2s_bus, 79'hx);
            else                chk("sb_bus", m1s_to_m2s_bus, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    logic [174:0] b, n;

    initial begin
        reset = 1'b0; es_to_m1s_valid = 1'b0; es_to_m1s_bus = '0;
        m2s_allowin = 1'b1; data_addr_ok = 1'b0; flush = 1'b0;
        #2;
        chk("rst_allowin", m1s_allowin, 1);
        chk("rst_req", data_req, 0);
        chk("rst_valid", m1s_to_m2s_valid, 0);
        chk("rst_bus", m1s_to_m2s_bus, 0);
        chk("rst_misc", {m1s_ex, m1s_inst_eret, m1s_load_op, M1_dest, data_wr, data_wstrb}, 0);
        chk("rst_addr", {data_addr, data_wdata, M1_result}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Load accepted in the same cycle it is requested.
        b = mk(0, 4'hf, 0, 1, 0, 0, 0, 1, 5'd5, 32'h8000_0010, 32'h100);
        es_to_m1s_valid = 1'b1; es_to_m1s_bus = b; sb.push_back(xo(1, b));
        #1; chk("ld_allowin", m1s_allowin, 1);
        tick();
        es_to_m1s_valid = 1'b0; data_addr_ok = 1'b1;
        #1;
        chk("ld_req", data_req, 1);
        chk("ld_fields", {data_wr, data_wstrb, data_addr}, {1'b0, 4'h0, 32'h8000_0010});
        chk("ld_out_valid", m1s_to_m2s_valid, 1);
        chk("ld_fwd", {m1s_load_op, M1_dest, M1_result}, {1'b1, 5'd5, 32'h8000_0010});
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("ld_req_drop", {data_req, m1s_to_m2s_valid}, 0);

        // Byte store with a 3-cycle accept delay; a younger ALU op waits behind it.
        b = mk(32'hABAB_ABAB, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 32'h2002, 32'h104);
        n = mk(0, 0, 0, 0, 0, 0, 1, 1, 5'd7, 32'h77, 32'h108);
        es_to_m1s_valid = 1'b1; es_to_m1s_bus = b; sb.push_back(xo(1, b));
        tick();
        es_to_m1s_bus = n; sb.push_back(xo(0, n));
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sb_req_hold", {data_req, data_wr, data_wstrb, data_addr, data_wdata},
                {1'b1, 1'b1, 4'b0100, 32'h2002, 32'hABAB_ABAB});
            chk("sb_stall", {m1s_allowin, m1s_to_m2s_valid}, 0);
            tick();
        end
        data_addr_ok = 1'b1;
        #1;
        chk("sb_accept", {data_req, m1s_allowin, m1s_to_m2s_valid}, 3'b111);
        tick();
        es_to_m1s_valid = 1'b0; data_addr_ok = 1'b0;
        #1;
        chk("alu_pass", {m1s_to_m2s_valid, data_req, m1s_inst_eret}, 3'b101);
        tick();

        // Store with an address exception: no request, passes with issued=0.
        b = mk(32'h1234, 4'hf, 1, 0, 1, 5'h05, 0, 0, 0, 32'h3001, 32'h10c);
        es_to_m1s_valid = 1'b1; es_to_m1s_bus = b; sb.push_back(xo(0, b));
        tick();
        es_to_m1s_valid = 1'b0;
        #1;
        chk("ex_noreq", {data_req, m1s_ex, m1s_to_m2s_valid}, 3'b011);
        tick();

        // Flush while a request is outstanding: drain it in CANCEL.
        b = mk(0, 0, 0, 1, 0, 0, 0, 1, 5'd3, 32'h4000, 32'h110);
        n = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h44, 32'h114);
        es_to_m1s_valid = 1'b1; es_to_m1s_bus = b;
        tick();
        es_to_m1s_valid = 1'b0;
        #1; chk("fl_req", data_req, 1);
        tick();
        flush = 1'b1;
        #1; chk("fl_flush_cycle", {data_req, m1s_to_m2s_valid}, 2'b10);
        tick();
        flush = 1'b0; es_to_m1s_valid = 1'b1; es_to_m1s_bus = n;
        #1;
        chk("fl_cancel1", {data_req, m1s_allowin, m1s_to_m2s_valid}, 3'b100);
        chk("fl_cancel_addr", data_addr, 32'h4000);
        tick();
        data_addr_ok = 1'b1;
        #1; chk("fl_cancel2", {data_req, m1s_allowin, m1s_to_m2s_valid}, 3'b100);
        tick();
        data_addr_ok = 1'b0;
        #1; chk("fl_idle", {data_req, m1s_allowin}, 2'b01);
        sb.push_back(xo(0, n));
        tick();
        es_to_m1s_valid = 1'b0;
        #1; chk("fl_next_out", m1s_to_m2s_valid, 1);
        tick();

        // Accepted while M2 is blocked: wait in DONE without re-requesting.
        b = mk(0, 0, 0, 1, 0, 0, 0, 1, 5'd9, 32'h5000, 32'h118);
        es_to_m1s_valid = 1'b1; es_to_m1s_bus = b; sb.push_back(xo(1, b));
        tick();
        es_to_m1s_valid = 1'b0; data_addr_ok = 1'b1; m2s_allowin = 1'b0;
        #1; chk("done_accept", {data_req, m1s_to_m2s_valid, m1s_allowin}, 3'b110);
        tick();
        data_addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1; chk("done_wait", {data_req, m1s_to_m2s_valid, m1s_allowin}, 3'b010);
            tick();
        end
        m2s_allowin = 1'b1;
        #1; chk("done_leave", {data_req, m1s_to_m2s_valid, m1s_allowin}, 3'b011);
        tick();
        #1; chk("done_empty", m1s_to_m2s_valid, 0);

        // Back-to-back loads with instant accept: one per cycle.
        data_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = mk(0, 0, 0, 1, 0, 0, 0, 1, 5'(i + 10), 32'h6000 + 32'(4 * i), 32'h200 + 32'(4 * i));
            es_to_m1s_valid = 1'b1; es_to_m1s_bus = b; sb.push_back(xo(1, b));
            #1;
            if (i > 0) chk("b2b_flow", {m1s_to_m2s_valid, data_req, m1s_allowin}, 3'b111);
            tick();
        end
        es_to_m1s_valid = 1'b0;
        #1; chk("b2b_last", {m1s_to_m2s_valid, data_addr}, {1'b1, 32'h600c});
        tick();
        data_addr_ok = 1'b0;
        #1; chk("b2b_drained", m1s_to_m2s_valid, 0);

        // Asynchronous reset in the middle of a request.
        b = mk(0, 0, 0, 1, 0, 0, 0, 1, 5'd1, 32'h7000, 32'h300);
        es_to_m1s_valid = 1'b1; es_to_m1s_bus = b;
        tick();
        es_to_m1s_valid = 1'b0;
        #1; chk("arst_pre", data_req, 1);
        reset = 1'b0;
        #1; chk("arst_drop", {data_req, m1s_allowin, m1s_to_m2s_valid, data_addr}, {3'b010, 32'h0});
        tick();
        reset = 1'b1;
        #1; chk("arst_after", {data_req, m1s_to_m2s_valid}, 0);

        chk("sb_empty", 79'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem1_stage.md
MEM1_STAGE -- requirements
Module: mem1_stage

Interface
REQ-001 Parameter IN_WD, default 175: width of es_to_m1s_bus.
REQ-002 Parameter OUT_WD, default 79: width of m1s_to_m2s_bus.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
REQ-004 Upstream and downstream handshake ports SHALL be:
- es_to_m1s_valid  in  1: EXE holds a valid instruction.
- es_to_m1s_bus  in  IN_WD: EXE payload.
- m1s_allowin  out  1: M1 can accept this cycle.
- m2s_allowin  in  1: M2 can accept.
- m1s_to_m2s_valid  out  1: M1 output valid.
- m1s_to_m2s_bus  out  OUT_WD: payload to M2.
REQ-005 Data SRAM request ports SHALL be:
- data_req  out  1: request valid.
- data_wr  out  1: 1 = store.
- data_wstrb  out  4: byte enables.
- data_addr  out  32: request address.
- data_wdata  out  32: store data.
- data_addr_ok  in  1: request accepted this cycle.
REQ-006 Control and forwarding ports SHALL be:
- flush  in  1: exception or eret redirect.
- m1s_ex  out  1: valid M1 instruction carries an exception.
- m1s_inst_eret  out  1: valid M1 eret.
- M1_dest  out  5: RF write address, zeroed when invalid.
- M1_result  out  32: alu_result forward.
- m1s_load_op  out  1: valid M1 load.

Function
REQ-007 Input fields SHALL be:
- wdata [174:143], wen [142:139], mem_we [138], load_op [133], ex [127], exctype [126:122], eret [120].
- gr_we [69], dest [68:64], alu_result [63:32], pc [31:0].
REQ-008 Output bus fields SHALL be:
- issued [78], ex [77], exctype [76:72], eret [71], load_op [70].
- gr_we [69], dest [68:64], alu_result [63:32], pc [31:0].
REQ-009 need_mem SHALL equal m1s_valid & (load_op|mem_we) & ~ex.
REQ-010 The request FSM SHALL have the states IDLE, REQ, DONE and CANCEL.
REQ-011 IDLE->REQ SHALL occur on the first cycle need_mem=1 and flush=0; data_req SHALL be driven combinationally in that same cycle.
REQ-012 In REQ, data_req SHALL be 1, with data_wr=mem_we, data_addr=alu_result, data_wstrb=wen (4'b0000 for loads), data_wdata=wdata, all held stable until data_addr_ok.
REQ-013 REQ->DONE SHALL occur on data_addr_ok when m2s_allowin=0; REQ->IDLE SHALL occur on data_addr_ok when m2s_allowin=1 (the instruction leaves in that cycle).
REQ-014 DONE->IDLE SHALL occur when the instruction leaves M1.
REQ-015 ready_go SHALL equal ~need_mem | (state==DONE) | ((state==IDLE|state==REQ) & data_req & data_addr_ok).
REQ-016 m1s_to_m2s_valid SHALL equal m1s_valid & ready_go & ~flush; issued SHALL be 1 iff a request was accepted for that instruction.
REQ-017 m1s_allowin SHALL equal (~m1s_valid | (ready_go & m2s_allowin)) & (state!=CANCEL).
REQ-018 Flush while data_req=1 and data_addr_ok=0: the block SHALL enter CANCEL, keep data_req and its fields stable until data_addr_ok, then go to IDLE; a request is never withdrawn.
REQ-019 Flush in any other state: the block SHALL go to IDLE with no request.
REQ-020 Any flush SHALL clear m1s_valid next cycle; the input register loads on m1s_allowin & es_to_m1s_valid & ~flush.
REQ-021 Instructions with ex=1 SHALL never raise data_req and SHALL pass with issued=0.
REQ-022 m1s_ex, m1s_inst_eret and m1s_load_op SHALL be gated by m1s_valid.

Reset
REQ-023 While reset=0, the block SHALL hold state=IDLE, m1s_valid=0 and the payload register all-zero.
REQ-024 While reset=0, every output SHALL be 0 except m1s_allowin, which SHALL be 1.
REQ-025 On reset assertion mid-REQ, data_req SHALL drop immediately (asynchronous reset).

Verification
REQ-026 Load, alu_result=0x8000_0010, data_addr_ok=1 same cycle, m2s_allowin=1 -> data_req for 1 cycle, data_wstrb=0, 1-cycle latency, issued=1.
REQ-027 sb, wen=4'b0100, wdata=0xABABABAB, data_addr_ok delayed 3 cycles -> data_req high 4 cycles with fields stable, m1s_allowin=0 until accept.
REQ-028 Store with ex=1, exctype=AdES -> no data_req; m1s_ex=1; output issued=0, exctype=AdES.
REQ-029 Flush in REQ, data_addr_ok after 2 cycles -> CANCEL, data_req held 2 cycles, m1s_to_m2s_valid=0, m1s_allowin=0 until IDLE.
REQ-030 Accept with m2s_allowin=0 for 2 cycles -> state DONE, no second request, instruction leaves when m2s_allowin=1.
REQ-031 Back-to-back loads with data_addr_ok tied to 1 -> one instruction per cycle, 0 bubbles.
